uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
- Sits directly downstream of rx_uart: consumes each received byte on its done tick.
- Assembles three consecutive bytes (operand A, operand B, opcode) and drives registered operands/opcode to the combinational ALU.
- Samples the ALU result and hands it to tx_uart with a one-cycle start pulse.
- Recovers from bad opcodes and inter-byte stalls.

Parameters:
- NB_DATA, 8, width of received bytes, operands and result.
- NB_OP, 6, opcode width (low bits of the opcode byte).
- NB_TIMEOUT, 20, width of the inter-byte timeout counter.
- TIMEOUT_CYCLES, 1000000, i_clock cycles allowed between bytes of one frame.

Ports:
- i_clock  in  1  system clock, same clock as rx_uart/tx_uart.
- i_reset  in  1  asynchronous, active-high reset.
- i_rx_done_tick  in  1  one-cycle pulse from rx_uart: byte valid.
- i_rx_data  in  NB_DATA  received byte, valid with the tick.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done_tick  in  1  one-cycle pulse from tx_uart: byte sent.
- o_data_a  out  NB_DATA  operand A to ALU.
- o_data_b  out  NB_DATA  operand B to ALU.
- o_op  out  NB_OP  opcode to ALU.
- o_tx_data  out  NB_DATA  byte to transmit.
- o_tx_start  out  1  one-cycle pulse: start transmission.
- o_err_tick  out  1  one-cycle pulse: frame aborted (bad opcode or timeout).
- o_busy  out  1  high from frame acceptance until i_tx_done_tick.

Behaviour:
- Reset (async, any state): state=WAIT_A; all outputs 0; internal A/B holding regs and timeout counter 0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX. State encoded in 3 bits.
- WAIT_A:
  - tick -> latch byte into hold_a, go WAIT_B, clear counter.
  - No timeout in WAIT_A.
- WAIT_B:
  - tick -> latch hold_b, go WAIT_OP, clear counter.
- WAIT_OP, tick with valid opcode -> at that edge load o_data_a=hold_a, o_data_b=hold_b, o_op=byte[NB_OP-1:0]; go EXEC.
- Valid opcode: upper NB_DATA-NB_OP bits zero AND low bits in {0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA, 0x02 SRL}.
- Invalid opcode:
  - o_err_tick=1 next cycle; go WAIT_A.
  - o_data_a/o_data_b/o_op keep previous values; no tx_start.
- Timeout:
  - In WAIT_B/WAIT_OP the counter increments each cycle without tick.
  - Reaching TIMEOUT_CYCLES-1 -> o_err_tick pulse, go WAIT_A, counter cleared.
  - Tick and expiry in same cycle: tick wins, no error.
- EXEC: one cycle for ALU settle; at its end edge o_tx_data <= i_alu_result; go SEND.
- SEND: o_tx_start=1 for exactly this cycle; go WAIT_TX.
- Latency: opcode tick in cycle T -> operands valid T+1, o_tx_start high in cycle T+2 only, o_tx_data stable from T+2 until next frame's EXEC.
- o_busy: 1 in EXEC, SEND, WAIT_TX; 0 otherwise.
- WAIT_TX:
  - i_rx_done_tick ignored (byte dropped, no error).
  - i_tx_done_tick -> WAIT_A.
  - Both ticks same cycle: go WAIT_A, rx byte dropped.
- i_tx_done_tick outside WAIT_TX: ignored.
- All outputs registered; no combinational path input->output.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with ALU model; tick spacing = 1 rx_uart frame -> o_data_a=0x05, o_data_b=0x03, o_op=0x20, o_tx_data=0x08, o_tx_start high one cycle at T+2, o_busy=1 until tx_done.
- Bytes 0xF0, 0x04, 0x03 (SRA) -> o_tx_data=0xFF; then 0x81, 0x01, 0x02 (SRL) -> o_tx_data=0x40.
- Bytes 0x05, 0x03, 0x3F -> o_err_tick one cycle, no o_tx_start, o_op unchanged, next frame 0x01, 0x01, 0x22 -> o_tx_data=0x00.
- Byte 0x05 then silence for TIMEOUT_CYCLES (bench param 50) -> o_err_tick, state WAIT_A; then 0x02, 0x02, 0x24 -> o_tx_data=0x02.
- Extra byte 0x77 injected during WAIT_TX -> ignored; next frame 0x0F, 0xF0, 0x25 -> o_tx_data=0xFF; with tx_done and rx_done coincident -> WAIT_A, byte dropped.
- Reset asserted mid-WAIT_OP and mid-WAIT_TX -> all outputs 0 immediately (async), o_busy=0, next full frame processes correctly.

Source files
------------

// File: rtl/uart_alu_interface.sv
// uart_alu_interface
//   Glue between rx_uart, a combinational ALU and tx_uart. Collects a
//   three-byte frame (operand A, operand B, opcode), presents registered
//   operands/opcode to the ALU, samples the result one cycle later and
//   launches it on tx_uart with a single-cycle start pulse. A frame is
//   aborted on an unknown opcode or when the gap between two of its bytes
//   runs past TIMEOUT_CYCLES.
//
// Ports
//   i_clock         system clock shared with rx_uart / tx_uart
//   i_reset         asynchronous, active-high reset
//   i_rx_done_tick  one-cycle pulse: i_rx_data holds a received byte
//   i_rx_data       received byte
//   i_alu_result    combinational ALU output
//   i_tx_done_tick  one-cycle pulse: tx_uart finished sending
//   o_data_a        operand A to ALU
//   o_data_b        operand B to ALU
//   o_op            opcode to ALU
//   o_tx_data       byte handed to tx_uart
//   o_tx_start      one-cycle pulse: start transmission
//   o_err_tick      one-cycle pulse: frame aborted
//   o_busy          high from frame acceptance until tx_uart is done
//
// State     | meaning
// ----------+---------------------------------------------------------
// WAIT_A    | idle, next byte is operand A (no timeout here)
// WAIT_B    | operand A held, waiting for operand B (timeout armed)
// WAIT_OP   | both operands held, waiting for opcode (timeout armed)
// EXEC      | operands/opcode on ALU, result settling
// SEND      | o_tx_start high for this one cycle
// WAIT_TX   | waiting for tx_uart done; received bytes are dropped

module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_err_tick,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'('h20);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'('h22);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'('h24);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'('h25);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'('h26);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'('h27);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'('h03);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'('h02);

  localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [NB_DATA-1:0]   hold_a_q, hold_a_d;
  logic [NB_DATA-1:0]   hold_b_q, hold_b_d;
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
  logic [NB_DATA-1:0]   data_a_q, data_a_d;
  logic [NB_DATA-1:0]   data_b_q, data_b_d;
  logic [NB_OP-1:0]     op_q, op_d;
  logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic op_valid;
  logic timeout_hit;
  logic wait_armed;

  // An opcode byte is accepted only when the bits above the opcode field
  // are zero and the field names one of the supported ALU operations.
  function automatic logic opcode_ok(input logic [NB_DATA-1:0] byte_in);
    logic [NB_OP-1:0] field;
    field = byte_in[NB_OP-1:0];
    opcode_ok = (byte_in[NB_DATA-1:NB_OP] == '0) &&
                (field inside {OP_ADD, OP_SUB, OP_AND, OP_OR,
                               OP_XOR, OP_NOR, OP_SRA, OP_SRL});
  endfunction

  assign op_valid    = opcode_ok(i_rx_data);
  assign wait_armed  = (state_q == WAIT_B) || (state_q == WAIT_OP);
  // A byte arriving on the terminal cycle still belongs to the frame.
  assign timeout_hit = wait_armed && !i_rx_done_tick && (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      cnt_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_a_q   <= hold_a_d;
      hold_b_q   <= hold_b_d;
      cnt_q      <= cnt_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_A: begin
        if (i_rx_done_tick) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (i_rx_done_tick)   state_d = WAIT_OP;
        else if (timeout_hit) state_d = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done_tick)   state_d = op_valid ? EXEC : WAIT_A;
        else if (timeout_hit) state_d = WAIT_A;
      end
      EXEC:    state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: begin
        if (i_tx_done_tick) state_d = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    hold_a_d   = hold_a_q;
    hold_b_d   = hold_b_q;
    cnt_d      = '0;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    err_d      = 1'b0;

    if (wait_armed && !i_rx_done_tick && !timeout_hit) begin
      cnt_d = cnt_q + NB_TIMEOUT'(1);
    end

    unique case (state_q)
      WAIT_A: begin
        if (i_rx_done_tick) hold_a_d = i_rx_data;
      end
      WAIT_B: begin
        if (i_rx_done_tick)   hold_b_d = i_rx_data;
        else if (timeout_hit) err_d    = 1'b1;
      end
      WAIT_OP: begin
        if (i_rx_done_tick) begin
          if (op_valid) begin
            data_a_d = hold_a_q;
            data_b_d = hold_b_q;
            op_d     = i_rx_data[NB_OP-1:0];
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      EXEC: begin
        // ALU has had the whole EXEC cycle to settle on the new operands.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d == EXEC) || (state_d == SEND) || (state_d == WAIT_TX);
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_err_tick = err_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed + randomized bench for uart_alu_interface. A simple ALU model
// closes the loop on i_alu_result; expected frame outcomes come from a
// byte-level model (gap length, opcode legality, ALU arithmetic).

module tb_uart_alu_interface;

  localparam int NB_DATA    = 8;
  localparam int NB_OP      = 6;
  localparam int NB_TIMEOUT = 20;
  localparam int TO         = 50;

  logic               i_clock;
  logic               i_reset;
  logic               i_rx_done_tick;
  logic [NB_DATA-1:0] i_rx_data;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done_tick;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_err_tick;
  logic               o_busy;

  uart_alu_interface #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_TIMEOUT(NB_TIMEOUT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_rx_done_tick(i_rx_done_tick), .i_rx_data(i_rx_data),
    .i_alu_result(i_alu_result), .i_tx_done_tick(i_tx_done_tick),
    .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_err_tick(o_err_tick), .o_busy(o_busy)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   alu_f = a + b;
      6'h22:   alu_f = a - b;
      6'h24:   alu_f = a & b;
      6'h25:   alu_f = a | b;
      6'h26:   alu_f = a ^ b;
      6'h27:   alu_f = ~(a | b);
      6'h03:   alu_f = 8'($signed(a) >>> b);
      6'h02:   alu_f = a >> b;
      default: alu_f = 8'h00;
    endcase
  endfunction

  always_comb i_alu_result = alu_f(o_data_a, o_data_b, o_op);

  function automatic bit legal_op(input logic [7:0] b);
    legal_op = b inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
  endfunction

  int n_assert = 0;
  int n_fail   = 0;
  int n_start_seen = 0, n_err_seen = 0;
  int n_start_exp  = 0, n_err_exp  = 0;

  logic [7:0] exp_a, exp_b, exp_tx;
  logic [5:0] exp_op;

  always @(negedge i_clock) begin
    if (o_tx_start) n_start_seen++;
    if (o_err_tick) n_err_seen++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data      = b;
    i_rx_done_tick = 1'b1;
    step();
    i_rx_done_tick = 1'b0;
    i_rx_data      = 8'($urandom);
  endtask

  // Tickless cycles; with noise, stray tx_done pulses that must be ignored.
  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      i_tx_done_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    i_tx_done_tick = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},     32'(o_data_a),   32'h0);
    chk({tag, "_b"},     32'(o_data_b),   32'h0);
    chk({tag, "_op"},    32'(o_op),       32'h0);
    chk({tag, "_tx"},    32'(o_tx_data),  32'h0);
    chk({tag, "_start"}, 32'(o_tx_start), 32'h0);
    chk({tag, "_err"},   32'(o_err_tick), 32'h0);
    chk({tag, "_busy"},  32'(o_busy),     32'h0);
  endtask

  task automatic model_reset();
    exp_a = 8'h0; exp_b = 8'h0; exp_op = 6'h0; exp_tx = 8'h0;
  endtask

  // mode: 0 plain, 1 stray rx byte in WAIT_TX, 2 rx+tx done coincident,
  //       3 reset while waiting for tx_done
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gab, input int gbo, input int mode);
    logic [7:0] new_tx;
    send_byte(a);
    idle(gab, 1'b1);
    send_byte(b);
    idle(gbo, 1'b1);
    send_byte(opb);
    if (legal_op(opb)) begin
      new_tx = alu_f(a, b, opb[5:0]);
      n_start_exp++;
      chk("t1_data_a", 32'(o_data_a),   32'(a));
      chk("t1_data_b", 32'(o_data_b),   32'(b));
      chk("t1_op",     32'(o_op),       32'(opb[5:0]));
      chk("t1_busy",   32'(o_busy),     32'h1);
      chk("t1_start",  32'(o_tx_start), 32'h0);
      chk("t1_err",    32'(o_err_tick), 32'h0);
      chk("t1_txhold", 32'(o_tx_data),  32'(exp_tx));
      exp_a = a; exp_b = b; exp_op = opb[5:0]; exp_tx = new_tx;
      step();
      chk("t2_start",  32'(o_tx_start), 32'h1);
      chk("t2_txdata", 32'(o_tx_data),  32'(exp_tx));
      chk("t2_busy",   32'(o_busy),     32'h1);
      step();
      chk("t3_start",  32'(o_tx_start), 32'h0);
      chk("t3_txdata", 32'(o_tx_data),  32'(exp_tx));
      chk("t3_busy",   32'(o_busy),     32'h1);
      idle($urandom_range(0, 3), 1'b0);
      case (mode)
        1: begin
          send_byte(8'h77);
          chk("wtx_drop_err",  32'(o_err_tick), 32'h0);
          chk("wtx_drop_busy", 32'(o_busy),     32'h1);
          i_tx_done_tick = 1'b1; step(); i_tx_done_tick = 1'b0;
          chk("done_busy", 32'(o_busy), 32'h0);
        end
        2: begin
          i_rx_data = 8'h11; i_rx_done_tick = 1'b1; i_tx_done_tick = 1'b1;
          step();
          i_rx_done_tick = 1'b0; i_tx_done_tick = 1'b0;
          chk("coinc_busy", 32'(o_busy),     32'h0);
          chk("coinc_err",  32'(o_err_tick), 32'h0);
        end
        3: begin
          i_reset = 1'b1;
          #1;
          chk_zero("rst_wtx");
          #2 i_reset = 1'b0;
          model_reset();
          step();
        end
        default: begin
          i_tx_done_tick = 1'b1; step(); i_tx_done_tick = 1'b0;
          chk("done_busy", 32'(o_busy), 32'h0);
        end
      endcase
      chk("post_txdata", 32'(o_tx_data), 32'(exp_tx));
    end else begin
      n_err_exp++;
      chk("bad_err",    32'(o_err_tick), 32'h1);
      chk("bad_op",     32'(o_op),       32'(exp_op));
      chk("bad_data_a", 32'(o_data_a),   32'(exp_a));
      chk("bad_start",  32'(o_tx_start), 32'h0);
      chk("bad_busy",   32'(o_busy),     32'h0);
      chk("bad_txdata", 32'(o_tx_data),  32'(exp_tx));
      step();
      chk("bad_err_off", 32'(o_err_tick), 32'h0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb, rop;
    i_reset = 1'b1; i_rx_done_tick = 1'b0; i_rx_data = 8'h0; i_tx_done_tick = 1'b0;
    model_reset();
    #12;
    chk_zero("reset");
    i_reset = 1'b0;
    step(); step();

    // Basic ADD, SRA, SRL
    run_frame(8'h05, 8'h03, 8'h20, 3, 3, 0);
    chk("tp_add", 32'(o_tx_data), 32'h08);
    run_frame(8'hF0, 8'h04, 8'h03, 2, 1, 0);
    chk("tp_sra", 32'(o_tx_data), 32'hFF);
    run_frame(8'h81, 8'h01, 8'h02, 0, 0, 0);
    chk("tp_srl", 32'(o_tx_data), 32'h40);

    // Illegal opcode, then recovery
    run_frame(8'h05, 8'h03, 8'h3F, 1, 1, 0);
    run_frame(8'h01, 8'h01, 8'h22, 1, 1, 0);
    chk("tp_sub", 32'(o_tx_data), 32'h00);

    // Timeout in WAIT_B
    send_byte(8'h05);
    idle(TO - 1, 1'b0);
    chk("to_b_pre", 32'(o_err_tick), 32'h0);
    step();
    n_err_exp++;
    chk("to_b_err",  32'(o_err_tick), 32'h1);
    chk("to_b_busy", 32'(o_busy),     32'h0);
    step();
    chk("to_b_off",  32'(o_err_tick), 32'h0);
    run_frame(8'h02, 8'h02, 8'h24, 1, 1, 0);
    chk("tp_and", 32'(o_tx_data), 32'h02);

    // Timeout in WAIT_OP
    send_byte(8'h01);
    send_byte(8'h02);
    idle(TO - 1, 1'b0);
    chk("to_op_pre", 32'(o_err_tick), 32'h0);
    step();
    n_err_exp++;
    chk("to_op_err", 32'(o_err_tick), 32'h1);
    step();

    // Byte on the terminal cycle beats the timeout
    run_frame(8'h09, 8'h06, 8'h22, TO - 1, TO - 1, 0);
    chk("tp_edge", 32'(o_tx_data), 32'h03);

    // Stray byte in WAIT_TX, then coincident ticks, then a clean frame
    run_frame(8'h0A, 8'h0B, 8'h20, 0, 0, 1);
    chk("tp_stray", 32'(o_tx_data), 32'h15);
    run_frame(8'h0F, 8'hF0, 8'h25, 1, 1, 2);
    chk("tp_or", 32'(o_tx_data), 32'hFF);
    run_frame(8'h03, 8'h04, 8'h26, 0, 0, 0);
    chk("tp_xor", 32'(o_tx_data), 32'h07);

    // Reset in WAIT_OP
    send_byte(8'h11);
    send_byte(8'h22);
    i_reset = 1'b1;
    #1;
    chk_zero("rst_wop");
    #2 i_reset = 1'b0;
    model_reset();
    step();
    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 0);
    chk("tp_rst1", 32'(o_tx_data), 32'h08);

    // Reset in WAIT_TX
    run_frame(8'h33, 8'h11, 8'h27, 0, 0, 3);
    run_frame(8'h40, 8'h02, 8'h22, 0, 0, 0);
    chk("tp_rst2", 32'(o_tx_data), 32'h3E);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        rop = 8'($urandom);
        while (legal_op(rop)) rop = 8'($urandom);
      end else begin
        case ($urandom_range(0, 7))
          0: rop = 8'h20; 1: rop = 8'h22; 2: rop = 8'h24; 3: rop = 8'h25;
          4: rop = 8'h26; 5: rop = 8'h27; 6: rop = 8'h03; default: rop = 8'h02;
        endcase
      end
      run_frame(ra, rb, rop, $urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 2));
    end

    step(); step();
    chk("start_count", 32'(n_start_seen), 32'(n_start_exp));
    chk("err_count",   32'(n_err_seen),   32'(n_err_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
